uart_rx: RTL and testbench

//  UART receiver, counterpart of the uart transmitter: 8N1 frames from pin rx into a FIFO.

---
 rtl/config_pkg.sv | 22 ++
 rtl/uart_rx_pkg.sv | 17 +
 rtl/uart_rx_fifo.sv | 43 ++++
 rtl/uart_rx.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/config_pkg.sv
// Shared SoC configuration: CSR bus types, operation encodings and UART receiver addresses.
package config_pkg;

   typedef logic [11:0] CsrAddrT;
   typedef logic [31:0] word;
   typedef logic [4:0]  r;

   typedef enum logic [2:0] {
      CSR_NONE = 3'b000,
      CSR_RW   = 3'b001,
      CSR_RS   = 3'b010,
      CSR_RC   = 3'b011,
      CSR_RWI  = 3'b101,
      CSR_RSI  = 3'b110,
      CSR_RCI  = 3'b111
   } csr_op_t;

   localparam CsrAddrT     RxDataAddr   = 12'hBC0;
   localparam CsrAddrT     RxStatusAddr = 12'hBC1;
   localparam int unsigned RxDepth      = 8;

endpackage

// File: rtl/uart_rx_pkg.sv
// UART receiver local types: frame state encoding and status register bit positions.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_rx_state_t;

   localparam int unsigned StHaveData = 0;
   localparam int unsigned StOvr      = 1;
   localparam int unsigned StFerr     = 2;
   localparam int unsigned StPerr     = 3;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO; pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_rx_fifo #(
   parameter int unsigned Depth = 8
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       push,
   input  logic [7:0] wdata,
   input  logic       pop,
   output logic [7:0] head,
   output logic       full,
   output logic       empty
);

   localparam int unsigned AW  = $clog2(Depth);
   localparam logic [AW:0] One = 1;

   logic [AW:0] wr_ptr, rd_ptr;
   logic [7:0]  mem [Depth];
   logic        do_push, do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // a pop on the same edge frees the slot a push into a full FIFO needs
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + One;
         if (do_pop)  rd_ptr <= rd_ptr + One;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a byte FIFO,
// with data and sticky status registers on the shared CSR bus.
module uart_rx
   import config_pkg::*;
   import uart_rx_pkg::*;
#(
   parameter int unsigned Depth      = RxDepth,
   parameter int unsigned PrescWidth = 16
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [PrescWidth-1:0] prescaler,
   input  logic                  rx,
   input  logic                  csr_enable,
   input  CsrAddrT               csr_addr,
   input  csr_op_t               csr_op,
   input  r                      rs1_zimm,
   input  word                   rs1_data,
   output word                   csr_data_out,
   output logic                  have_data
);

   localparam logic [PrescWidth-1:0] CntOne = 1;

   logic                  rx_meta, rx_s;
   uart_rx_state_t        state, state_next;
   logic [PrescWidth-1:0] cnt, cnt_next;
   logic [2:0]            idx, idx_next;
   logic [7:0]            shreg, shreg_next;
   logic                  push, ferr_set, ovr_set;
   logic                  ferr, ovr;
   logic [7:0]            head;
   logic                  full, empty;
   logic                  data_hit, stat_hit, clr_en;
   word                   clr_mask;
   logic                  mask_unused;
`ifdef UART_RX_PARITY_EN
   logic                  perr, perr_set, par_bad, par_bad_next;
`endif

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      idx_next   = idx;
      shreg_next = shreg;
      push       = 1'b0;
      ferr_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_set     = 1'b0;
      par_bad_next = par_bad;
`endif
      case (state)
         ST_IDLE: begin
            if (!rx_s) begin
               state_next = ST_START;
               cnt_next   = prescaler >> 1;
            end
         end
         ST_START: begin
            if (cnt != '0) cnt_next = cnt - CntOne;
            else if (rx_s) state_next = ST_IDLE;
            else begin
               state_next = ST_DATA;
               cnt_next   = prescaler;
               idx_next   = '0;
            end
         end
         ST_DATA: begin
            if (cnt != '0) cnt_next = cnt - CntOne;
            else begin
               shreg_next[idx] = rx_s;
               cnt_next        = prescaler;
               idx_next        = idx + 3'd1;
`ifdef UART_RX_PARITY_EN
               if (idx == 3'd7) state_next = ST_PARITY;
`else
               if (idx == 3'd7) state_next = ST_STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (cnt != '0) cnt_next = cnt - CntOne;
            else begin
               par_bad_next = (rx_s != ^shreg);
               perr_set     = (rx_s != ^shreg);
               cnt_next     = prescaler;
               state_next   = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (cnt != '0) cnt_next = cnt - CntOne;
            else begin
               state_next = ST_IDLE;
               ferr_set   = !rx_s;
`ifdef UART_RX_PARITY_EN
               push       = rx_s && !par_bad;
`else
               push       = rx_s;
`endif
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         state   <= ST_IDLE;
         cnt     <= '0;
         idx     <= '0;
         shreg   <= '0;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         state   <= state_next;
         cnt     <= cnt_next;
         idx     <= idx_next;
         shreg   <= shreg_next;
      end
   end

   assign data_hit    = csr_enable && (csr_addr == RxDataAddr);
   assign stat_hit    = csr_enable && (csr_addr == RxStatusAddr);
   assign clr_en      = stat_hit && ((csr_op == CSR_RC) || (csr_op == CSR_RCI));
   assign clr_mask    = (csr_op == CSR_RCI) ? {27'b0, rs1_zimm} : rs1_data;
   assign mask_unused = ^clr_mask[31:3];
   assign ovr_set     = push && full && !data_hit;
   assign have_data   = !empty;

   // set terms are OR-ed in last so a same-edge set beats a clear
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         ferr <= 1'b0;
         ovr  <= 1'b0;
      end else begin
         ferr <= (ferr && !(clr_en && clr_mask[StFerr])) || ferr_set;
         ovr  <= (ovr  && !(clr_en && clr_mask[StOvr]))  || ovr_set;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         perr    <= 1'b0;
         par_bad <= 1'b0;
      end else begin
         perr    <= (perr && !(clr_en && clr_mask[StPerr])) || perr_set;
         par_bad <= par_bad_next;
      end
   end
`endif

   always_comb begin
      csr_data_out = '0;
      if (csr_addr == RxDataAddr) begin
         if (!empty) csr_data_out[7:0] = head;
      end else if (csr_addr == RxStatusAddr) begin
         csr_data_out[StHaveData] = have_data;
         csr_data_out[StOvr]      = ovr;
         csr_data_out[StFerr]     = ferr;
`ifdef UART_RX_PARITY_EN
         csr_data_out[StPerr]     = perr;
`endif
      end
   end

   uart_rx_fifo #(
      .Depth(Depth)
   ) u_fifo (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .push   (push),
      .wdata  (shreg),
      .pop    (data_hit),
      .head   (head),
      .full   (full),
      .empty  (empty)
   );

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written FIFO/reset corner cases.
module tb_uart_rx;
   import config_pkg::*;
   import uart_rx_pkg::*;

   localparam int unsigned Depth  = 8;
   localparam int unsigned BitCyc = 8;
`ifdef UART_RX_PARITY_EN
   localparam int unsigned NBits = 11;
`else
   localparam int unsigned NBits = 10;
`endif
   localparam int unsigned FrameCyc = NBits * BitCyc;
   localparam int unsigned StopEdge = FrameCyc - 1;

   logic        clk = 1'b0;
   logic        reset_i = 1'b0;
   logic [15:0] prescaler = 16'd7;
   logic        rx = 1'b1;
   logic        csr_enable = 1'b0;
   CsrAddrT     csr_addr = '0;
   csr_op_t     csr_op = CSR_NONE;
   r            rs1_zimm = '0;
   word         rs1_data = '0;
   word         csr_data_out;
   logic        have_data;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic        hd_trace [FrameCyc + 1];
   word         pop_rd;
   word         rd;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      word        exp_status;
      word        exp_pop;
   } vec_t;
   vec_t vecs [5];

   always #5 clk = ~clk;

   uart_rx #(
      .Depth     (Depth),
      .PrescWidth(16)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .prescaler   (prescaler),
      .rx          (rx),
      .csr_enable  (csr_enable),
      .csr_addr    (csr_addr),
      .csr_op      (csr_op),
      .rs1_zimm    (rs1_zimm),
      .rs1_data    (rs1_data),
      .csr_data_out(csr_data_out),
      .have_data   (have_data)
   );

   task automatic check(input string name, input word act, input word exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // called on a negedge; returns the read value and finishes on the next negedge
   task automatic csr(input CsrAddrT a, input csr_op_t op, input r zimm, input word d, output word val);
      csr_enable = 1'b1;
      csr_addr   = a;
      csr_op     = op;
      rs1_zimm   = zimm;
      rs1_data   = d;
      #1 val = csr_data_out;
      @(negedge clk);
      csr_enable = 1'b0;
      csr_addr   = '0;
      csr_op     = CSR_NONE;
      rs1_zimm   = '0;
      rs1_data   = '0;
   endtask

   task automatic read_status(output word val);
      csr(RxStatusAddr, CSR_RS, '0, '0, val);
   endtask

   task automatic pop_data(output word val);
      csr(RxDataAddr, CSR_RS, '0, '0, val);
   endtask

   function automatic logic frame_bit(input logic [7:0] d, input logic stop, input logic par,
                                      input int unsigned slot);
      if (slot == 0) return 1'b0;
      if (slot <= 8) return d[slot-1];
`ifdef UART_RX_PARITY_EN
      if (slot == 9) return par;
`else
      if (par === 1'bx) return 1'b1;
`endif
      return stop;
   endfunction

   // hd_trace[k] holds have_data at the k-th negedge after the start bit was driven
   task automatic drive_frame(input logic [7:0] d, input logic stop, input logic par,
                              input int unsigned ncyc, input int pop_at);
      for (int unsigned c = 0; c < ncyc; c++) begin
         rx = frame_bit(d, stop, par, c / BitCyc);
         if (int'(c) == pop_at) begin
            csr_enable = 1'b1;
            csr_addr   = RxDataAddr;
            csr_op     = CSR_RS;
            #1 pop_rd  = csr_data_out;
         end else begin
            csr_enable = 1'b0;
            csr_addr   = '0;
            csr_op     = CSR_NONE;
         end
         @(negedge clk);
         hd_trace[c+1] = have_data;
      end
      csr_enable = 1'b0;
      csr_addr   = '0;
      csr_op     = CSR_NONE;
      rx         = 1'b1;
   endtask

   task automatic send(input logic [7:0] d);
      drive_frame(d, 1'b1, ^d, FrameCyc, -1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{8'hA5, 1'b1, 32'h1, 32'hA5};
      vecs[1] = '{8'h00, 1'b1, 32'h1, 32'h00};
      vecs[2] = '{8'hFF, 1'b1, 32'h1, 32'hFF};
      vecs[3] = '{8'h81, 1'b1, 32'h1, 32'h81};
      vecs[4] = '{8'h3C, 1'b0, 32'h4, 32'h00};

      // reset state
      repeat (3) @(negedge clk);
      csr_addr = RxStatusAddr;
      #1 check("reset status", csr_data_out, 32'h0);
      csr_addr = RxDataAddr;
      #1 check("reset data", csr_data_out, 32'h0);
      check("reset have_data", have_data, 32'h0);
      csr_addr = '0;
      reset_i  = 1'b1;
      repeat (4) @(negedge clk);

      // single frames, one read of status and data each
      for (int i = 0; i < 5; i++) begin
         drive_frame(vecs[i].data, vecs[i].stop, ^vecs[i].data, FrameCyc, -1);
         check($sformatf("vec%0d hd before stop edge", i), hd_trace[StopEdge-1], 32'h0);
         check($sformatf("vec%0d hd after stop edge", i), hd_trace[StopEdge], {31'b0, vecs[i].exp_status[0]});
         read_status(rd);
         check($sformatf("vec%0d status", i), rd, vecs[i].exp_status);
         pop_data(rd);
         check($sformatf("vec%0d pop", i), rd, vecs[i].exp_pop);
         check($sformatf("vec%0d hd after pop", i), have_data, 32'h0);
      end

      // sticky FERR: set-op leaves it, clear-op removes it
      csr(RxStatusAddr, CSR_RSI, 5'd4, '0, rd);
      check("rsi status old", rd, 32'h4);
      read_status(rd);
      check("ferr kept after rsi", rd, 32'h4);
      csr(RxStatusAddr, CSR_RCI, 5'd4, '0, rd);
      check("rci status old", rd, 32'h4);
      read_status(rd);
      check("ferr cleared", rd, 32'h0);

      // start-bit glitch rejected, receiver still usable afterwards
      rx = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      check("glitch have_data", have_data, 32'h0);
      read_status(rd);
      check("glitch status", rd, 32'h0);
      send(8'h96);
      pop_data(rd);
      check("after glitch pop", rd, 32'h96);

      // overflow: Depth+1 frames unread
      for (int k = 1; k <= 9; k++) send(8'(k));
      read_status(rd);
      check("ovr status", rd, 32'h3);
      for (int k = 1; k <= 8; k++) begin
         pop_data(rd);
         check($sformatf("ovr pop%0d", k), rd, word'(k));
      end
      pop_data(rd);
      check("ovr pop empty", rd, 32'h0);
      read_status(rd);
      check("ovr sticky", rd, 32'h2);
      csr(RxStatusAddr, CSR_RC, '0, 32'h2, rd);
      read_status(rd);
      check("ovr cleared", rd, 32'h0);

      // full FIFO: pop and push on the stop-sample edge
      for (int k = 1; k <= 8; k++) send(8'(k));
      drive_frame(8'h09, 1'b1, ^8'h09, FrameCyc, int'(StopEdge) - 1);
      check("full pop+push head", pop_rd, 32'h01);
      read_status(rd);
      check("full pop+push status", rd, 32'h1);
      for (int k = 2; k <= 9; k++) begin
         pop_data(rd);
         check($sformatf("full pop+push pop%0d", k), rd, word'(k));
      end
      pop_data(rd);
      check("full pop+push empty", rd, 32'h0);

      // empty FIFO: pop and push on the same edge
      drive_frame(8'h77, 1'b1, ^8'h77, FrameCyc, int'(StopEdge) - 1);
      check("empty pop+push read", pop_rd, 32'h0);
      check("empty pop+push hd", have_data, 32'h1);
      pop_data(rd);
      check("empty pop+push pop", rd, 32'h77);
      pop_data(rd);
      check("empty pop+push empty", rd, 32'h0);

      // reset during data bit 4 drops the partial byte
      drive_frame(8'hC3, 1'b1, ^8'hC3, 5 * BitCyc + 4, -1);
      reset_i = 1'b0;
      repeat (2) @(negedge clk);
      reset_i = 1'b1;
      repeat (10) @(negedge clk);
      check("midreset have_data", have_data, 32'h0);
      send(8'h5A);
      pop_data(rd);
      check("midreset pop", rd, 32'h5A);
      pop_data(rd);
      check("midreset empty", rd, 32'h0);
      read_status(rd);
      check("midreset status", rd, 32'h0);

`ifdef UART_RX_PARITY_EN
      drive_frame(8'h07, 1'b1, 1'b0, FrameCyc, -1);
      read_status(rd);
      check("perr status", rd, 32'h8);
      check("perr have_data", have_data, 32'h0);
      csr(RxStatusAddr, CSR_RCI, 5'd8, '0, rd);
      read_status(rd);
      check("perr cleared", rd, 32'h0);
      drive_frame(8'h07, 1'b1, 1'b1, FrameCyc, -1);
      pop_data(rd);
      check("parity ok pop", rd, 32'h07);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
